// File: rtl/cortez_layer_pkg.sv
// Shared types and helpers for the time-multiplexed neural layer family:
// FSM state encoding, derived-size functions and output saturation.
package cortez_layer_pkg;

  typedef enum logic [2:0] {StIdle, StMac, StBias, StArgmax, StDone} layer_state_e;

  // Full-precision accumulator width; sized so a full dot product cannot wrap.
  function automatic int unsigned acc_w(input int unsigned width, input int unsigned num_inputs);
    return 2 * width + $clog2(num_inputs) + 1;
  endfunction

  function automatic int unsigned total(input int unsigned num_outputs,
                                        input int unsigned num_inputs,
                                        input int unsigned width);
    return num_outputs * (num_inputs + 1) * width;
  endfunction

  // Clamp a signed value to the range of a width-bit two's-complement word.
  function automatic longint saturate(input longint v, input int unsigned width,
                                      output logic clip);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (width - 1)) - 1;
    lo = -hi - 1;
    clip = 1'b0;
    if (v > hi) begin
      clip = 1'b1;
      return hi;
    end
    if (v < lo) begin
      clip = 1'b1;
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/shared_output_layer_if.sv
// Stream and config-chain signals of the shared output layer. The master side
// is the producer / configuring agent; the slave side is the layer itself.
interface shared_output_layer_if #(
  parameter int unsigned NUM_OUTPUTS = 4,
  parameter int unsigned WIDTH       = 8
);
  localparam int unsigned CLASS_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

  logic                         csn;
  logic                         sin;
  logic                         sout;
  logic                         sack;
  logic                         ready;
  logic [WIDTH-1:0]             value_in;
  logic                         valid_in;
  logic [NUM_OUTPUTS*WIDTH-1:0] values_out;
  logic [CLASS_W-1:0]           class_out;
  logic                         valid_out;
  logic                         overflow;

  modport master (
    output csn, sin, value_in, valid_in,
    input  sout, sack, ready, values_out, class_out, valid_out, overflow
  );

  modport slave (
    input  csn, sin, value_in, valid_in,
    output sout, sack, ready, values_out, class_out, valid_out, overflow
  );

endinterface

// File: rtl/sat_round.sv
// Rescales a fixed-point accumulator to data precision, adds a bias and
// saturates to WIDTH bits, flagging any clip. Purely combinational.
module sat_round
  import cortez_layer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAC_BITS = 3,
  parameter int unsigned ACC_W     = 19
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [WIDTH-1:0] bias,
  output logic signed [WIDTH-1:0] result,
  output logic                    clip
);

  logic signed [ACC_W-1:0] scaled;
  logic signed [ACC_W:0]   sum;
  longint                  sat;

  always_comb begin
    // Arithmetic shift floors toward minus infinity.
    scaled = acc >>> FRAC_BITS;
    sum    = {scaled[ACC_W-1], scaled} + {{(ACC_W + 1 - WIDTH){bias[WIDTH-1]}}, bias};
    sat    = saturate(longint'(sum), WIDTH, clip);
    result = WIDTH'(sat);
  end

endmodule

// File: rtl/shared_output_layer.sv
// Fully-connected output layer with one shared MAC engine, serial weight/bias
// chain, saturating bias stage, sticky overflow and argmax classification.
module shared_output_layer
  import cortez_layer_pkg::*;
#(
  parameter int unsigned NUM_INPUTS  = 4,
  parameter int unsigned NUM_OUTPUTS = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned FRAC_BITS   = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  shared_output_layer_if.slave bus
);

  localparam int unsigned ACC_W  = acc_w(WIDTH, NUM_INPUTS);
  localparam int unsigned TOTAL  = total(NUM_OUTPUTS, NUM_INPUTS, WIDTH);
  localparam int unsigned OW     = $clog2(NUM_OUTPUTS);
  localparam int unsigned IW     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned STRIDE = NUM_INPUTS + 1;

  layer_state_e state_q, state_d;
  logic [OW-1:0] o_q, o_d;
  logic [IW-1:0] i_q, i_d;

  logic [TOTAL-1:0]        chain_q;
  logic                    shifted_q;
  logic                    sack_q;
  logic signed [WIDTH-1:0] x_q;
  logic signed [ACC_W-1:0] acc_q [NUM_OUTPUTS];
  logic signed [WIDTH-1:0] res_q [NUM_OUTPUTS];
  logic signed [WIDTH-1:0] best_val_q;
  logic [OW-1:0]           best_idx_q;
  logic                    ovf_pend_q;
  logic [NUM_OUTPUTS*WIDTH-1:0] values_q;
  logic [OW-1:0]           class_q;
  logic                    ovf_q;

  logic signed [WIDTH-1:0] w_arr [NUM_OUTPUTS][NUM_INPUTS];
  logic signed [WIDTH-1:0] b_arr [NUM_OUTPUTS];

  // Chain word k = o*(NUM_INPUTS+1)+i; the last word of each neuron is its bias.
  for (genvar go = 0; go < NUM_OUTPUTS; go++) begin : g_words
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_w
      assign w_arr[go][gi] = chain_q[(go*STRIDE + gi)*WIDTH +: WIDTH];
    end
    assign b_arr[go] = chain_q[(go*STRIDE + NUM_INPUTS)*WIDTH +: WIDTH];
  end

  logic accept, o_last, i_last;
  assign accept = (state_q == StIdle) && bus.csn && bus.valid_in;
  assign o_last = (o_q == OW'(NUM_OUTPUTS - 1));
  assign i_last = (i_q == IW'(NUM_INPUTS - 1));

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    i_d     = i_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          o_d     = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        if (o_last) begin
          o_d = '0;
          if (i_last) begin
            state_d = StBias;
          end else begin
            i_d     = i_q + IW'(1);
            state_d = StIdle;
          end
        end else begin
          o_d = o_q + OW'(1);
        end
      end
      StBias: begin
        if (o_last) begin
          o_d     = '0;
          state_d = StArgmax;
        end else begin
          o_d = o_q + OW'(1);
        end
      end
      StArgmax: begin
        if (o_last) begin
          o_d     = '0;
          state_d = StDone;
        end else begin
          o_d = o_q + OW'(1);
        end
      end
      StDone: begin
        i_d     = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      o_q     <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      i_q     <= i_d;
    end
  end

  // Datapath: MAC, bias/saturate and argmax all address neuron o_q.
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc_sel, acc_base, mac_sum;
  logic signed [WIDTH-1:0]   sat_res, cand, best_val_nx;
  logic                      sat_clip, take;
  logic [OW-1:0]             best_idx_nx;

  always_comb begin
    acc_sel     = acc_q[o_q];
    prod        = x_q * w_arr[o_q][i_q];
    acc_base    = (i_q == '0) ? '0 : acc_sel;
    mac_sum     = acc_base + {{(ACC_W - 2*WIDTH){prod[2*WIDTH-1]}}, prod};
    cand        = res_q[o_q];
    take        = (o_q == '0) || (cand > best_val_q);
    best_idx_nx = take ? o_q : best_idx_q;
    best_val_nx = take ? cand : best_val_q;
  end

  sat_round #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .ACC_W     (ACC_W)
  ) u_sat_round (
    .acc    (acc_sel),
    .bias   (b_arr[o_q]),
    .result (sat_res),
    .clip   (sat_clip)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      ovf_pend_q <= 1'b0;
      values_q   <= '0;
      class_q    <= '0;
      ovf_q      <= 1'b0;
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
        acc_q[k] <= '0;
        res_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        x_q        <= bus.value_in;
        ovf_pend_q <= 1'b0;
      end
      if (state_q == StMac) acc_q[o_q] <= mac_sum;
      if (state_q == StBias) begin
        res_q[o_q] <= sat_res;
        if (sat_clip) ovf_pend_q <= 1'b1;
      end
      if (state_q == StArgmax) begin
        best_idx_q <= best_idx_nx;
        best_val_q <= best_val_nx;
        // Publish on entry to DONE so outputs are current while valid_out is high.
        if (o_last) begin
          for (int k = 0; k < NUM_OUTPUTS; k++) values_q[k*WIDTH +: WIDTH] <= res_q[k];
          class_q <= best_idx_nx;
          ovf_q   <= ovf_pend_q;
        end
      end
    end
  end

  // Config chain only moves in IDLE; sack follows the first idle csn-high cycle after a shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q   <= '0;
      shifted_q <= 1'b0;
      sack_q    <= 1'b0;
    end else begin
      sack_q <= 1'b0;
      if (state_q == StIdle) begin
        if (!bus.csn) begin
          chain_q   <= {chain_q[TOTAL-2:0], bus.sin};
          shifted_q <= 1'b1;
        end else if (shifted_q) begin
          sack_q    <= 1'b1;
          shifted_q <= 1'b0;
        end
      end
    end
  end

  assign bus.sout       = chain_q[TOTAL-1];
  assign bus.sack       = sack_q;
  assign bus.ready      = (state_q == StIdle) && bus.csn;
  assign bus.values_out = values_q;
  assign bus.class_out  = class_q;
  assign bus.valid_out  = (state_q == StDone);
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_shared_output_layer.sv
// Self-checking bench for shared_output_layer: table vectors, random vectors
// against an arithmetic reference, and hand-written config/reset sequences.
module tb_shared_output_layer;

  localparam int unsigned NI    = 2;
  localparam int unsigned NO    = 3;
  localparam int unsigned W     = 8;
  localparam int unsigned FRAC  = 3;
  localparam int unsigned TOTAL = NO * (NI + 1) * W;
  localparam int          LAT   = 3 * NO + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shared_output_layer_if #(.NUM_OUTPUTS(NO), .WIDTH(W)) bus ();

  shared_output_layer #(
    .NUM_INPUTS  (NI),
    .NUM_OUTPUTS (NO),
    .WIDTH       (W),
    .FRAC_BITS   (FRAC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int w[NO*NI];
    int b[NO];
    int x[NI];
    int ey[NO];
    int ecls;
    int eovf;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int sack_cnt = 0;

  always @(posedge clk) begin
    if (rst_n && bus.ready && bus.valid_in) acc_cnt <= acc_cnt + 1;
    if (bus.sack) sack_cnt <= sack_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [TOTAL-1:0] got,
                          input logic [TOTAL-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer dot product, floor-divide by 2^FRAC, add bias, clamp.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int acc, q;
    r = v;
    r.eovf = 0;
    for (int o = 0; o < NO; o++) begin
      acc = 0;
      for (int i = 0; i < NI; i++) acc += v.x[i] * v.w[o*NI + i];
      q = acc / (1 << FRAC);
      if (acc < 0 && (acc % (1 << FRAC)) != 0) q = q - 1;
      q = q + v.b[o];
      if (q > 127) begin q = 127; r.eovf = 1; end
      if (q < -128) begin q = -128; r.eovf = 1; end
      r.ey[o] = q;
    end
    r.ecls = 0;
    for (int o = 1; o < NO; o++) if (r.ey[o] > r.ey[r.ecls]) r.ecls = o;
    return r;
  endfunction

  function automatic logic [TOTAL-1:0] pack_cfg(input vec_t v);
    logic [TOTAL-1:0] bits;
    int val;
    bits = '0;
    for (int o = 0; o < NO; o++)
      for (int i = 0; i <= NI; i++) begin
        val = (i < NI) ? v.w[o*NI + i] : v.b[o];
        bits[(o*(NI+1) + i)*W +: W] = W'(val);
      end
    return bits;
  endfunction

  task automatic end_cfg();
    bus.csn = 1'b1;
    bus.sin = 1'b0;
    @(posedge clk); #1;
    chk("sack_pulse", int'(bus.sack), 1);
    @(posedge clk); #1;
    chk("sack_single", int'(bus.sack), 0);
  endtask

  task automatic load_cfg(input logic [TOTAL-1:0] bits);
    bus.csn = 1'b0;
    for (int j = TOTAL - 1; j >= 0; j--) begin
      bus.sin = bits[j];
      if (j == TOTAL - 1) begin
        #1 chk("ready_low_cfg", int'(bus.ready), 0);
      end
      @(posedge clk); #1;
    end
    end_cfg();
  endtask

  task automatic run_inf(input int x0, input int x1, output logic [NO*W-1:0] vals,
                         output int cls, output int ovf, output int lat);
    int xs[NI];
    int n;
    xs[0] = x0;
    xs[1] = x1;
    vals = '0; cls = -1; ovf = -1; lat = -1;
    for (int k = 0; k < NI; k++) begin
      bus.value_in = W'(xs[k]);
      bus.valid_in = 1'b1;
      n = 0;
      @(negedge clk);
      while (bus.ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (bus.ready !== 1'b1) begin
        chk("accept_timeout", 0, 1);
        bus.valid_in = 1'b0;
        return;
      end
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
    end
    for (n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (bus.valid_out === 1'b1) break;
    end
    lat  = n;
    vals = bus.values_out;
    cls  = int'(bus.class_out);
    ovf  = int'(bus.overflow);
    @(posedge clk); #1;
    chk("valid_out_pulse", int'(bus.valid_out), 0);
  endtask

  task automatic check_results(input string name, input vec_t v, input logic [NO*W-1:0] vals,
                               input int cls, input int ovf);
    for (int o = 0; o < NO; o++)
      chk($sformatf("%s_y%0d", name, o), int'($signed(vals[o*W +: W])), v.ey[o]);
    chk({name, "_class"}, cls, v.ecls);
    chk({name, "_ovf"}, ovf, v.eovf);
  endtask

  task automatic check_vec(input string name, input vec_t v);
    logic [NO*W-1:0] vals;
    int cls, ovf, lat;
    load_cfg(pack_cfg(v));
    run_inf(v.x[0], v.x[1], vals, cls, ovf, lat);
    check_results(name, v, vals, cls, ovf);
    chk({name, "_latency"}, lat, LAT);
  endtask

  vec_t tbl[5];
  vec_t rv;
  logic [TOTAL-1:0] pat, cap;
  logic [NO*W-1:0] vals;
  int a0, s0, n;

  initial begin
    tbl[0].w = '{8, 0, 0, 8, -8, -8};   tbl[0].b = '{0, 4, 0};     tbl[0].x = '{16, 8};
    tbl[0].ey = '{16, 12, -24};          tbl[0].ecls = 0;           tbl[0].eovf = 0;
    tbl[1].w = '{127, 127, 127, 127, 127, 127}; tbl[1].b = '{0, 0, 0}; tbl[1].x = '{127, 127};
    tbl[1].ey = '{127, 127, 127};        tbl[1].ecls = 0;           tbl[1].eovf = 1;
    tbl[2] = tbl[0];
    tbl[3].w = '{-8, 0, 8, 8, 8, 8};     tbl[3].b = '{0, 0, 0};     tbl[3].x = '{-8, -8};
    tbl[3].ey = '{8, -16, -16};          tbl[3].ecls = 0;           tbl[3].eovf = 0;
    tbl[4].w = '{8, 8, -8, 0, 0, -8};    tbl[4].b = '{0, 0, 0};     tbl[4].x = '{-8, -8};
    tbl[4].ey = '{-16, 8, 8};            tbl[4].ecls = 1;           tbl[4].eovf = 0;

    rst_n = 1'b0;
    bus.csn = 1'b1;
    bus.sin = 1'b0;
    bus.valid_in = 1'b0;
    bus.value_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_values", int'(bus.values_out), 0);
    chk("rst_class", int'(bus.class_out), 0);
    chk("rst_ovf", int'(bus.overflow), 0);
    chk("rst_valid", int'(bus.valid_out), 0);
    chk("rst_sack", int'(bus.sack), 0);
    chk("rst_sout", int'(bus.sout), 0);
    rst_n = 1'b1;
    #1 chk("rst_ready", int'(bus.ready), 1);
    @(posedge clk); #1;

    for (int t = 0; t < 5; t++) check_vec($sformatf("tbl%0d", t), tbl[t]);

    // Config readback: shifting zeros replays the loaded pattern MSB first.
    pat = {8'($urandom), $urandom, $urandom};
    load_cfg(pat);
    bus.csn = 1'b0;
    bus.sin = 1'b0;
    for (int j = 0; j < int'(TOTAL); j++) begin
      cap[TOTAL-1-j] = bus.sout;
      @(posedge clk); #1;
    end
    chk_wide("readback", cap, pat);
    end_cfg();
    chk("chain_flushed_sout", int'(bus.sout), 0);

    // Backpressure and csn abuse during BIAS/ARGMAX.
    load_cfg(pack_cfg(tbl[0]));
    a0 = acc_cnt;
    s0 = sack_cnt;
    bus.value_in = 8'd16;
    bus.valid_in = 1'b1;
    @(posedge clk); #1;
    bus.value_in = 8'd8;
    for (n = 0; n < 20 && acc_cnt != a0 + 2; n++) begin
      @(posedge clk); #1;
    end
    bus.valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.csn = 1'b0;
    bus.sin = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.csn = 1'b1;
    bus.sin = 1'b0;
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.valid_out === 1'b1) break;
    end
    chk("abuse_valid_seen", int'(bus.valid_out), 1);
    check_results("abuse", tbl[0], bus.values_out, int'(bus.class_out), int'(bus.overflow));
    repeat (4) @(posedge clk);
    #1;
    chk("abuse_accepts", acc_cnt - a0, 2);
    chk("abuse_no_sack", sack_cnt - s0, 0);

    // Asynchronous reset in the middle of MAC.
    load_cfg(pack_cfg(tbl[4]));
    bus.value_in = 8'd16;
    bus.valid_in = 1'b1;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_values", int'(bus.values_out), 0);
    chk("midrst_class", int'(bus.class_out), 0);
    chk("midrst_ovf", int'(bus.overflow), 0);
    chk("midrst_valid", int'(bus.valid_out), 0);
    chk("midrst_sout", int'(bus.sout), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_vec("post_rst", tbl[0]);

    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < int'(NO*NI); k++) rv.w[k] = int'($urandom_range(255)) - 128;
      for (int k = 0; k < int'(NO); k++) rv.b[k] = int'($urandom_range(255)) - 128;
      for (int k = 0; k < int'(NI); k++) rv.x[k] = int'($urandom_range(255)) - 128;
      rv = model(rv);
      check_vec($sformatf("rand%0d", r), rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
